// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-bus RAM responder: bus widths and handshake FSM states.
// Latency: not applicable; this file holds declarations only.
// Backpressure: not applicable; this file holds declarations only.
package bus_pkg;

    localparam int DATA_W     = 32;
    localparam int SEL_W      = 4;
    localparam int ADR_BUS_W  = 32;
    localparam int BYTE_LANES = DATA_W / 8;
    localparam int WAIT_CNT_W = 4;     // holds WAIT_STATES (0..15)

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACK
    } state_t;

endpackage

// File: rtl/bus_ram_responder_if.sv
// Bundles the stb/ack/we/sel data-bus signals between the CPU (master) and the RAM responder (slave).
// Latency: none; this is wiring only.
// Backpressure: the slave holds ack_o until the master drops stb_i.
// Signals: stb_i, we_i, adr_i, dat_i, sel_i flow from master to slave.
//          ack_o, dat_o, bad_access_o flow from slave to master.
interface bus_ram_responder_if;
    import bus_pkg::*;

    logic                 stb_i;
    logic                 we_i;
    logic [ADR_BUS_W-1:0] adr_i;
    logic [DATA_W-1:0]    dat_i;
    logic [SEL_W-1:0]     sel_i;
    logic                 ack_o;
    logic [DATA_W-1:0]    dat_o;
    logic                 bad_access_o;

    modport master (
        output stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o, bad_access_o
    );

    modport slave (
        input  stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o, bad_access_o
    );

endinterface

// File: rtl/bus_ram_array.sv
// Byte-lane-enabled single-port synchronous RAM with registered read.
// Latency: writes land and reads appear on the clock edge where en is high.
// Backpressure: none; one access per enabled cycle, the caller sequences requests.
// Ports: clk/rst (rst clears only the read register), en (access strobe), we (1 = write),
//        rd_zero (read returns 0 instead of memory), idx (word index), sel (byte lanes),
//        wdat (lane-aligned write data), rdat (registered read data, held between reads).
module bus_ram_array
    import bus_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] idx,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] wdat,
    output logic [DATA_W-1:0] rdat
);

    localparam string unused_init_file = INIT_FILE;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage has no reset so a bus reset never disturbs memory contents.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < BYTE_LANES; k++) begin
                if (sel[k]) begin
                    mem[idx][8*k +: 8] <= wdat[8*k +: 8];
                end
            end
        end
    end

    // Read register updates only on reads, so it holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdat <= '0;
        end else if (en && !we) begin
            rdat <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/bus_ram_responder.sv
// Slave responder for the CPU stb/ack data bus in front of on-chip RAM, with a sticky illegal-access flag.
// Latency: ack_o rises 1+WAIT_STATES edges after stb_i is first sampled; read data arrives with ack_o.
// Backpressure: ack_o is held until the master drops stb_i; no new request is taken while ack_o is high.
// Ports: clk, rst_i (synchronous, active-high), bus (slave modport of bus_ram_responder_if).
// Build option: define BUSRAM_ROM_PROTECT_EN to make word indices below ROM_WORDS read-only.
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter int    ADDR_W      = 10,
    parameter int    WAIT_STATES = 0,
    parameter int    ROM_WORDS   = 256,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst_i,
    bus_ram_responder_if.slave   bus
);

    // Request captured on the accepting edge; later bus changes are ignored.
    typedef struct packed {
        logic              we;
        logic              oor;     // address above the implemented array
        logic [ADDR_W-1:0] idx;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } req_t;

    state_t                state;
    state_t                state_nxt;
    req_t                  req;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  ack;
    logic                  bad;

    logic                  req_load;
    logic                  cnt_dec;
    logic                  ack_nxt;
    logic                  set_bad;
    logic                  ram_en;
    logic                  rom_hit;
    logic                  write_ok;
    logic [DATA_W-1:0]     rdat;

    // Byte offset bits play no part in a word-wide access.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^bus.adr_i[1:0];

`ifdef BUSRAM_ROM_PROTECT_EN
    assign rom_hit = ({{(32-ADDR_W){1'b0}}, req.idx} < 32'(ROM_WORDS));
`else
    localparam int unused_rom_words = ROM_WORDS;
    assign rom_hit = 1'b0;
`endif

    assign write_ok = req.we && !req.oor && !rom_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.stb_i) begin
                    state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            // Counter is loaded with WAIT_STATES; leaving at 1 gives exactly WAIT_STATES wait cycles.
            ST_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_ACK;
            ST_ACK: begin
                if (!bus.stb_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        req_load = 1'b0;
        cnt_dec  = 1'b0;
        ack_nxt  = 1'b0;
        set_bad  = 1'b0;
        ram_en   = 1'b0;
        case (state)
            ST_IDLE:   req_load = bus.stb_i;
            ST_WAIT:   cnt_dec  = 1'b1;
            ST_ACCESS: begin
                // Blocked writes skip the RAM entirely; reads always go so dat_o gets 0 when out of range.
                // Gating with rst_i keeps a reset on this edge from committing the write.
                ram_en  = !rst_i && (!req.we || write_ok);
                set_bad = req.oor || (req.we && rom_hit);
                ack_nxt = 1'b1;
            end
            ST_ACK:    ack_nxt  = bus.stb_i;
            default:   ack_nxt  = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            req <= '0;
            cnt <= '0;
            ack <= 1'b0;
            bad <= 1'b0;
        end else begin
            ack <= ack_nxt;
            if (set_bad) begin
                bad <= 1'b1;
            end
            if (req_load) begin
                req.we  <= bus.we_i;
                req.oor <= |(bus.adr_i >> (ADDR_W + 2));
                req.idx <= bus.adr_i[ADDR_W+1:2];
                req.sel <= bus.sel_i;
                req.dat <= bus.dat_i;
                cnt     <= WAIT_CNT_W'(WAIT_STATES);
            end else if (cnt_dec) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    bus_ram_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rst     (rst_i),
        .en      (ram_en),
        .we      (req.we),
        .rd_zero (req.oor),
        .idx     (req.idx),
        .sel     (req.sel),
        .wdat    (req.dat),
        .rdat    (rdat)
    );

    assign bus.ack_o        = ack;
    assign bus.dat_o        = rdat;
    assign bus.bad_access_o = bad;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) share one driver; a monitor checks each ack.
// Latency: ack latency, hold and release are checked by the driver against 1+WAIT_STATES.
// Backpressure: the driver holds stb one cycle into ack, as the CPU master does.
module tb_bus_ram_responder;

    typedef struct {
        logic [31:0] dat;
        logic        bad;
        logic        chk_dat;
    } exp_t;

`ifdef BUSRAM_ROM_PROTECT_EN
    localparam logic [31:0] BASE = 32'h0000_0800;
`else
    localparam logic [31:0] BASE = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst3 = 1'b1;
    logic        tgt = 1'b0;      // 0 selects the 0-wait DUT, 1 the 3-wait DUT
    logic        tb_stb = 1'b0;
    logic        tb_we = 1'b0;
    logic [31:0] tb_adr = '0;
    logic [31:0] tb_dat = '0;
    logic [3:0]  tb_sel = '0;
    logic        ack;
    logic [31:0] obs_dat;
    logic        obs_bad;
    logic        ack_q = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bus_ram_responder_if b0 ();
    bus_ram_responder_if b3 ();

    assign b0.stb_i = tb_stb & ~tgt;
    assign b0.we_i  = tb_we;
    assign b0.adr_i = tb_adr;
    assign b0.dat_i = tb_dat;
    assign b0.sel_i = tb_sel;
    assign b3.stb_i = tb_stb & tgt;
    assign b3.we_i  = tb_we;
    assign b3.adr_i = tb_adr;
    assign b3.dat_i = tb_dat;
    assign b3.sel_i = tb_sel;

    assign ack     = tgt ? b3.ack_o : b0.ack_o;
    assign obs_dat = tgt ? b3.dat_o : b0.dat_o;
    assign obs_bad = tgt ? b3.bad_access_o : b0.bad_access_o;

    bus_ram_responder #(.ADDR_W(10), .WAIT_STATES(0), .ROM_WORDS(256), .INIT_FILE("")) dut0 (
        .clk(clk), .rst_i(rst0), .bus(b0));
    bus_ram_responder #(.ADDR_W(10), .WAIT_STATES(3), .ROM_WORDS(256), .INIT_FILE("")) dut3 (
        .clk(clk), .rst_i(rst3), .bus(b3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] forbidden);
        n_vec++;
        if (act === forbidden) begin
            n_bad++;
            $display("FAIL %s: got %h which must differ from %h", name, act, forbidden);
        end
    endtask

    // Monitor: on each rising ack, pop the next expectation and compare.
    always @(negedge clk) begin
        if (ack && !ack_q) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack with data %h, required no ack", obs_dat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_dat) chk("read_data", obs_dat, e.dat);
                chk("bad_flag", {31'd0, obs_bad}, {31'd0, e.bad});
            end
        end
        ack_q = ack;
    end

    // Entered and left at #1 after a rising edge.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] ed, input logic eb, input logic cd);
        int n;
        int lat;
        lat = (tgt ? 3 : 0) + 1;
        tb_we = w; tb_adr = a; tb_dat = d; tb_sel = s; tb_stb = 1'b1;
        exp_q.push_back('{dat: ed, bad: eb, chk_dat: cd});
        @(posedge clk);                 // E0: request accepted
        #1;
        // Scramble the bus; only the latched request may matter.
        tb_adr = $urandom; tb_dat = $urandom; tb_sel = 4'($urandom); tb_we = ~w;
        n = 0;
        while (!ack && n < 40) begin
            @(posedge clk); n++; #1;
        end
        chk("ack_latency", n, lat);
        @(posedge clk); #1;
        chk("ack_hold", {31'd0, ack}, 32'd1);
        tb_stb = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0;
        chk("rst_ack0", {31'd0, b0.ack_o}, 32'd0);
        chk("rst_dat0", b0.dat_o, 32'd0);
        chk("rst_bad0", {31'd0, b0.bad_access_o}, 32'd0);
        chk("rst_ack3", {31'd0, b3.ack_o}, 32'd0);
        chk("rst_dat3", b3.dat_o, 32'd0);
        chk("rst_bad3", {31'd0, b3.bad_access_o}, 32'd0);

        // Zero wait states
        tgt = 1'b0;
        txn(1, BASE + 32'h10, 32'hCAFEBABE, 4'b1111, 32'h00000000, 0, 1);
        txn(0, BASE + 32'h10, 32'h0,        4'b1111, 32'hCAFEBABE, 0, 1);
        txn(1, BASE + 32'h12, 32'h00550000, 4'b0100, 32'hCAFEBABE, 0, 1);
        txn(0, BASE + 32'h10, 32'h0,        4'b0000, 32'hCA55BABE, 0, 1);
        txn(1, BASE + 32'h10, 32'hFFFFFFFF, 4'b0000, 32'hCA55BABE, 0, 1);
        txn(0, BASE + 32'h10, 32'h0,        4'b0001, 32'hCA55BABE, 0, 1);
        txn(1, BASE + 32'h14, 32'h11223344, 4'b1111, 32'hCA55BABE, 0, 1);
        txn(1, BASE + 32'h17, 32'hAABBCCDD, 4'b1001, 32'hCA55BABE, 0, 1);
        txn(0, BASE + 32'h14, 32'h0,        4'b1111, 32'hAA2233DD, 0, 1);
        // Out of range for ADDR_W=10
        txn(0, 32'h00001000,  32'h0,        4'b1111, 32'h00000000, 1, 1);
        txn(0, BASE + 32'h10, 32'h0,        4'b1111, 32'hCA55BABE, 1, 1);
        txn(1, 32'h80000010,  32'h12345678, 4'b1111, 32'hCA55BABE, 1, 1);
        txn(0, BASE + 32'h10, 32'h0,        4'b1111, 32'hCA55BABE, 1, 1);
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        chk("bad_cleared", {31'd0, b0.bad_access_o}, 32'd0);

        // Three wait states
        tgt = 1'b1;
        txn(1, BASE + 32'h20, 32'h0BADF00D, 4'b1111, 32'h00000000, 0, 1);
        txn(0, BASE + 32'h20, 32'h0,        4'b1111, 32'h0BADF00D, 0, 1);

        // Reset while waiting aborts a write
        tb_we = 1'b1; tb_adr = BASE + 32'h20; tb_dat = 32'hDEADBEEF; tb_sel = 4'b1111; tb_stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst3 = 1'b1; tb_stb = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait_ack", {31'd0, ack}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_wait_ack_later", {31'd0, ack}, 32'd0);
        chk("rst_wait_dat", obs_dat, 32'd0);
        rst3 = 1'b0;
        txn(0, BASE + 32'h20, 32'h0, 4'b1111, 32'h0BADF00D, 0, 1);

        // Strobe dropped during WAIT: access still completes with a one-cycle ack
        tb_we = 1'b1; tb_adr = BASE + 32'h24; tb_dat = 32'h600DCAFE; tb_sel = 4'b1111; tb_stb = 1'b1;
        exp_q.push_back('{dat: 32'h0BADF00D, bad: 1'b0, chk_dat: 1'b1});
        @(posedge clk); #1;
        tb_stb = 1'b0;
        n = 0;
        while (!ack && n < 40) begin
            @(posedge clk); n++; #1;
        end
        chk("short_stb_latency", n, 4);
        @(posedge clk); #1;
        chk("short_stb_pulse", {31'd0, ack}, 32'd0);
        txn(0, BASE + 32'h24, 32'h0, 4'b1111, 32'h600DCAFE, 0, 1);

`ifdef BUSRAM_ROM_PROTECT_EN
        tgt = 1'b0;
        txn(1, 32'h00000040, 32'h11111111, 4'b1111, 32'h0, 1, 0);
        txn(0, 32'h00000040, 32'h0,        4'b1111, 32'h0, 1, 0);
        chk_ne("rom_unchanged", obs_dat, 32'h11111111);
        txn(1, 32'h00000400, 32'h55AA55AA, 4'b1111, 32'h0, 1, 0);
        txn(0, 32'h00000400, 32'h0,        4'b1111, 32'h55AA55AA, 1, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
